soft_error_ctrl: RTL and testbench

Per-channel soft-error counting and threshold controller for the Rider.
- Channels: data corruption (checksum mismatch), unknown TTC broadcast command, DDR3 overflow.
- Counts single-cycle event pulses, compares each count against its IPbus-programmed threshold, and raises sticky hard-error flags.
- Sequences software-initiated counter clears through a 4-phase handshake.
- Outputs feed the status register block: counts, error bits and warnings.

---
 rtl/soft_error_pkg.sv | 24 ++
 rtl/soft_error_chan.sv | 75 +++++++
 rtl/soft_error_ctrl.sv | 92 +++++++++
 tb/tb_soft_error_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soft_error_pkg.sv
// -----------------------------------------------------------------------------
// soft_error_pkg
// Shared definitions for the soft-error counting controller:
//   - default channel count and counter width
//   - channel index assignments
//   - clear-handshake FSM state encoding
// Optional feature macro used by the design: SOFT_ERR_WARN_EN
// -----------------------------------------------------------------------------
package soft_error_pkg;

    localparam int NUM_CH_DEFAULT = 3;
    localparam int CNT_W_DEFAULT  = 32;

    // Channel index assignments
    localparam int CH_DATA_CORRUPT  = 0;
    localparam int CH_UNKNOWN_TTC   = 1;
    localparam int CH_DDR3_OVERFLOW = 2;

    // Clear-handshake FSM states
    localparam logic [1:0] ST_MONITOR = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

endpackage

// File: rtl/soft_error_chan.sv
// -----------------------------------------------------------------------------
// soft_error_chan
// One monitored channel: saturating event counter, sticky threshold error and
// (optionally) a half-threshold warning.
// Optional feature macro: SOFT_ERR_WARN_EN (warning compare present when defined)
// Ports:
//   clk      - clock
//   reset    - asynchronous, active-high reset
//   event_in - one-cycle event pulse
//   clear    - one-cycle clear strobe from the controller FSM
//   thres    - threshold; 0 disables error and warning
//   count    - current count
//   error    - sticky threshold error
//   warning  - half-threshold warning (0 when feature disabled)
// -----------------------------------------------------------------------------
module soft_error_chan
    import soft_error_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_in,
    input  logic             clear,
    input  logic [CNT_W-1:0] thres,
    output logic [CNT_W-1:0] count,
    output logic             error,
    output logic             warning
);

    logic err_set;

    // Compare uses the registered count, so the error lands one cycle after
    // the count reaches threshold.
    assign err_set = (thres != '0) && (count >= thres);

    // A clear takes priority over the sticky error, and an event arriving in
    // the clear cycle is folded in so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            error <= 1'b0;
        end else if (clear) begin
            count <= event_in ? CNT_W'(1) : '0;
            error <= 1'b0;
        end else begin
            if (event_in && (count != {CNT_W{1'b1}})) begin
                count <= count + CNT_W'(1);
            end
            if (err_set) begin
                error <= 1'b1;
            end
        end
    end

`ifdef SOFT_ERR_WARN_EN
    logic warn_set;

    assign warn_set = (thres != '0) && (count >= (thres >> 1));

    // Non-sticky: tracks count and threshold every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warning <= 1'b0;
        end else if (clear) begin
            warning <= 1'b0;
        end else begin
            warning <= warn_set;
        end
    end
`else
    assign warning = 1'b0;
`endif

endmodule

// File: rtl/soft_error_ctrl.sv
// -----------------------------------------------------------------------------
// soft_error_ctrl
// Per-channel soft-error counting and threshold controller. Counts event
// pulses, raises sticky threshold errors and sequences software clears
// through a 4-phase req/ack handshake.
// Optional feature macro: SOFT_ERR_WARN_EN (enables warning_out)
// Ports:
//   clk         - user interface clock
//   reset       - asynchronous, active-high reset
//   event_in    - one-cycle event pulses, bit i = channel i
//   thres       - per-channel thresholds, channel i at [i*CNT_W +: CNT_W]
//   clear_req   - clear request level
//   clear_mask  - channels to clear, latched when the request is accepted
//   clear_ack   - clear acknowledge
//   count_out   - current counts
//   error_out   - sticky per-channel threshold errors
//   error_any   - OR of error_out
//   warning_out - half-threshold warnings
// -----------------------------------------------------------------------------
module soft_error_ctrl
    import soft_error_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       event_in,
    input  logic [NUM_CH*CNT_W-1:0] thres,
    input  logic                    clear_req,
    input  logic [NUM_CH-1:0]       clear_mask,
    output logic                    clear_ack,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH-1:0]       error_out,
    output logic                    error_any,
    output logic [NUM_CH-1:0]       warning_out
);

    logic [1:0]        state;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] clear_chan;

    // Clear handshake: the mask is captured on acceptance, the clear is applied
    // for exactly one cycle, then ack is held until the request drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_MONITOR;
            mask  <= '0;
        end else begin
            case (state)
                ST_MONITOR: begin
                    if (clear_req) begin
                        mask  <= clear_mask;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    if (!clear_req) begin
                        state <= ST_MONITOR;
                    end
                end
                default: begin
                    state <= ST_MONITOR;
                end
            endcase
        end
    end

    // Decoded from the state register so that reset removes ack at once.
    assign clear_ack  = (state == ST_ACK);
    assign clear_chan = (state == ST_CLEAR) ? mask : '0;
    assign error_any  = |error_out;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        soft_error_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .event_in(event_in[i]),
            .clear   (clear_chan[i]),
            .thres   (thres[i*CNT_W +: CNT_W]),
            .count   (count_out[i*CNT_W +: CNT_W]),
            .error   (error_out[i]),
            .warning (warning_out[i])
        );
    end

endmodule

// File: tb/tb_soft_error_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soft_error_ctrl
// Directed scoreboard bench for soft_error_ctrl. Expectations are queued as
// stimulus is applied and popped when the corresponding output is sampled.
// Counters are narrowed to 8 bits so saturation is reachable quickly.
// Honours SOFT_ERR_WARN_EN for the expected warning values.
// -----------------------------------------------------------------------------
module tb_soft_error_ctrl;
    import soft_error_pkg::*;

    localparam int NCH = 3;
    localparam int CW  = 8;

`ifdef SOFT_ERR_WARN_EN
    localparam logic WARN_ON = 1'b1;
`else
    localparam logic WARN_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    event_in;
    logic [NCH*CW-1:0] thres;
    logic              clear_req;
    logic [NCH-1:0]    clear_mask;
    logic              clear_ack;
    logic [NCH*CW-1:0] count_out;
    logic [NCH-1:0]    error_out;
    logic              error_any;
    logic [NCH-1:0]    warning_out;

    int          tests_run    = 0;
    int          tests_failed = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    soft_error_ctrl #(
        .NUM_CH(NCH),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .event_in   (event_in),
        .thres      (thres),
        .clear_req  (clear_req),
        .clear_mask (clear_mask),
        .clear_ack  (clear_ack),
        .count_out  (count_out),
        .error_out  (error_out),
        .error_any  (error_any),
        .warning_out(warning_out)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] count_of(int ch);
        return 32'(count_out[ch*CW +: CW]);
    endfunction

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_thres(int ch, logic [CW-1:0] value);
        thres[ch*CW +: CW] = value;
    endtask

    task automatic expectValue(string tag, logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    // Drive the handshake/event inputs, then clock once
    task automatic applyStimulus(logic [NCH-1:0] ev, logic req, logic [NCH-1:0] mask);
        event_in   = ev;
        clear_req  = req;
        clear_mask = mask;
        tick();
    endtask

    task automatic pulse(int ch, int n);
        event_in[ch] = 1'b1;
        repeat (n) tick();
        event_in[ch] = 1'b0;
    endtask

    task automatic checkOutput(logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $error("[TB] FAIL scoreboard_underflow: observed %0h with nothing expected", observed);
        end else begin
            tag      = tag_q.pop_front();
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                tests_failed++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        event_in   = '0;
        thres      = '0;
        clear_req  = 1'b0;
        clear_mask = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        expectValue("reset_count", 32'h0);
        expectValue("reset_error", 32'h0);
        expectValue("reset_any",   32'h0);
        expectValue("reset_ack",   32'h0);
        expectValue("reset_warn",  32'h0);
        checkOutput(32'(count_out));
        checkOutput(32'(error_out));
        checkOutput(32'(error_any));
        checkOutput(32'(clear_ack));
        checkOutput(32'(warning_out));
        reset = 1'b0;

        // Threshold trip on channel 0
        set_thres(CH_DATA_CORRUPT, 8'd5);
        expectValue("t1_count0",    32'd5);
        expectValue("t1_err_early", 32'h0);
        pulse(CH_DATA_CORRUPT, 5);
        checkOutput(count_of(CH_DATA_CORRUPT));
        checkOutput(32'(error_out));
        expectValue("t1_error",  32'h1);
        expectValue("t1_any",    32'h1);
        expectValue("t1_others", 32'h0);
        tick();
        checkOutput(32'(error_out));
        checkOutput(32'(error_any));
        checkOutput(count_of(CH_UNKNOWN_TTC) + count_of(CH_DDR3_OVERFLOW));

        // Saturation with threshold disabled on channel 1
        set_thres(CH_UNKNOWN_TTC, 8'd0);
        expectValue("t2_sat_count", 32'hFF);
        pulse(CH_UNKNOWN_TTC, 260);
        checkOutput(count_of(CH_UNKNOWN_TTC));
        expectValue("t2_error", 32'h1);
        expectValue("t2_warn1", 32'h0);
        tick();
        checkOutput(32'(error_out));
        checkOutput(32'(warning_out[CH_UNKNOWN_TTC]));

        // Masked clear of channel 0 while channel 2 is also in error
        set_thres(CH_DDR3_OVERFLOW, 8'd3);
        pulse(CH_DDR3_OVERFLOW, 3);
        expectValue("t3_err_both", 32'h5);
        tick();
        checkOutput(32'(error_out));
        expectValue("t3_ack_clear_cycle", 32'h0);
        applyStimulus(3'b000, 1'b1, 3'b001);
        checkOutput(32'(clear_ack));
        expectValue("t3_count0",  32'h0);
        expectValue("t3_error",   32'h4);
        expectValue("t3_count2",  32'd3);
        expectValue("t3_count1",  32'hFF);
        expectValue("t3_ack",     32'h1);
        // Mask changes after acceptance must be ignored
        applyStimulus(3'b000, 1'b1, 3'b111);
        checkOutput(count_of(CH_DATA_CORRUPT));
        checkOutput(32'(error_out));
        checkOutput(count_of(CH_DDR3_OVERFLOW));
        checkOutput(count_of(CH_UNKNOWN_TTC));
        checkOutput(32'(clear_ack));
        expectValue("t3_ack_held",   32'h1);
        expectValue("t3_no_reclear", 32'h4);
        repeat (3) applyStimulus(3'b000, 1'b1, 3'b111);
        checkOutput(32'(clear_ack));
        checkOutput(32'(error_out));
        expectValue("t3_ack_drop", 32'h0);
        applyStimulus(3'b000, 1'b0, 3'b000);
        checkOutput(32'(clear_ack));

        // Event coincident with the clear cycle on channel 2
        set_thres(CH_DDR3_OVERFLOW, 8'd4);
        applyStimulus(3'b000, 1'b1, 3'b100);
        expectValue("t4_count2", 32'd1);
        expectValue("t4_error",  32'h0);
        expectValue("t4_ack",    32'h1);
        applyStimulus(3'b100, 1'b1, 3'b100);
        checkOutput(count_of(CH_DDR3_OVERFLOW));
        checkOutput(32'(error_out));
        checkOutput(32'(clear_ack));
        applyStimulus(3'b000, 1'b0, 3'b000);
        expectValue("t4_no_stale_error", 32'h0);
        tick();
        checkOutput(32'(error_out));

        // Empty-mask handshake leaves everything alone
        applyStimulus(3'b000, 1'b1, 3'b000);
        expectValue("t4b_ack", 32'h1);
        applyStimulus(3'b000, 1'b1, 3'b000);
        checkOutput(32'(clear_ack));
        applyStimulus(3'b000, 1'b0, 3'b000);
        expectValue("t4b_count2", 32'd1);
        expectValue("t4b_count1", 32'hFF);
        checkOutput(count_of(CH_DDR3_OVERFLOW));
        checkOutput(count_of(CH_UNKNOWN_TTC));

        // Threshold lowered below the current count on channel 1
        applyStimulus(3'b000, 1'b1, 3'b010);
        applyStimulus(3'b000, 1'b1, 3'b010);
        applyStimulus(3'b000, 1'b0, 3'b000);
        set_thres(CH_UNKNOWN_TTC, 8'd20);
        expectValue("t5_count1", 32'd10);
        expectValue("t5_error",  32'h0);
        expectValue("t5_warn",   32'({1'b0, WARN_ON, 1'b0}));
        pulse(CH_UNKNOWN_TTC, 10);
        tick();
        checkOutput(count_of(CH_UNKNOWN_TTC));
        checkOutput(32'(error_out));
        checkOutput(32'(warning_out));
        set_thres(CH_UNKNOWN_TTC, 8'd8);
        expectValue("t5_error_lowered", 32'h2);
        expectValue("t5_any",           32'h1);
        tick();
        checkOutput(32'(error_out));
        checkOutput(32'(error_any));
        set_thres(CH_UNKNOWN_TTC, 8'd20);
        expectValue("t5_error_sticky", 32'h2);
        repeat (2) tick();
        checkOutput(32'(error_out));

        // Half-threshold warning, then reset in the middle of ACK
        set_thres(CH_DATA_CORRUPT, 8'd8);
        expectValue("t6_warn", 32'({1'b0, WARN_ON, WARN_ON}));
        expectValue("t6_err0", 32'h0);
        pulse(CH_DATA_CORRUPT, 4);
        tick();
        checkOutput(32'(warning_out));
        checkOutput(32'(error_out[CH_DATA_CORRUPT]));
        applyStimulus(3'b000, 1'b1, 3'b000);
        expectValue("t6_ack_before_reset", 32'h1);
        applyStimulus(3'b000, 1'b1, 3'b000);
        checkOutput(32'(clear_ack));
        #2;
        reset = 1'b1;
        #1;
        expectValue("t6_ack_async",   32'h0);
        expectValue("t6_count_async", 32'h0);
        expectValue("t6_error_async", 32'h0);
        expectValue("t6_any_async",   32'h0);
        expectValue("t6_warn_async",  32'h0);
        checkOutput(32'(clear_ack));
        checkOutput(32'(count_out));
        checkOutput(32'(error_out));
        checkOutput(32'(error_any));
        checkOutput(32'(warning_out));

        // Request already high when reset releases: accepted straight away
        @(posedge clk);
        #1;
        reset = 1'b0;
        expectValue("t6_clear_cycle_ack", 32'h0);
        expectValue("t6_ack_after_reset", 32'h1);
        tick();
        checkOutput(32'(clear_ack));
        tick();
        checkOutput(32'(clear_ack));
        expectValue("t6_ack_final", 32'h0);
        applyStimulus(3'b000, 1'b0, 3'b000);
        checkOutput(32'(clear_ack));

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
